unidad_procesadora_pipe: RTL
============================

UNIDAD_PROCESADORA_PIPE -- requirements
Module: unidad_procesadora_pipe

Interface
REQ-001 SHALL have parameter W, default 4, data/register width (>=4).
REQ-002 SHALL have parameter NREG, default 8, register count (power of 2, >=2); AW = clog2(NREG), CW = 3*AW+7.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  control word/operands presented.
REQ-006 SHALL have port in_ready  output  1  block accepts this cycle.
REQ-007 SHALL have port control  input  CW  fields MSB->LSB: DA[AW], AA[AW], BA[AW], MB, FS[4], MD, RW.
REQ-008 SHALL have port datain  input  W  external data for MD=1 writeback.
REQ-009 SHALL have port constant_in  input  W  substitutes bus B when MB=1.
REQ-010 SHALL have port flags  output  4  {V,C,N,Z} of the presented result.
REQ-011 SHALL have port dataout  output  W  bus B value of the presented op.
REQ-012 SHALL have port adr_out  output  W  bus A value of the presented op.
REQ-013 SHALL have port out_valid  output  1  result stage holds a valid op.
REQ-014 SHALL have port out_ready  input  1  downstream accepts result.

Function
REQ-015 SHALL accept an op when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-016 SHALL be 2-stage: EX (read, mux, function unit) registered into WB; accepted op appears on outputs with out_valid=1 the next cycle (latency 1).
REQ-017 SHALL read A = R[AA], B = MB ? constant_in : R[BA] in EX.
REQ-018 SHALL forward WB write value to A and/or B when WB transfers this cycle with RW=1 and DA equals AA/BA (BA only if MB=0).
REQ-019 SHALL compute F by FS: 0000 A, 0001 A+1, 0010 A+B, 0011 A+B+1, 0100 A+~B, 0101 A+~B+1, 0110 A-1, 0111 A, 1000 A&B, 1001 A|B, 1010 A^B, 1011 ~A, 1100 B, 1101 B>>1, 1110 B<<1, 1111 zero.
REQ-020 SHALL compute arithmetic mod 2^W; C = carry-out of W-bit add, V = signed overflow, for FS 0000-0111.
REQ-021 SHALL set C = shifted-out bit, V=0 for 1101/1110; C=V=0 for logic, 1100, 1111; zero-fill shifts.
REQ-022 SHALL set N = F[W-1], Z = (F==0) for every FS.
REQ-023 SHALL write writeback value (MD ? datain : F) to R[DA] exactly once, on the cycle the WB op transfers (out_valid && out_ready) with RW=1.
REQ-024 SHALL hold flags, dataout, adr_out, out_valid stable while out_valid && !out_ready.
REQ-025 SHALL accept a new op in the same cycle WB transfers (full throughput, no bubbles).
REQ-026 SHALL leave outputs unchanged and out_valid low when no op is accepted and WB empties.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear all registers R[0..NREG-1], flags, dataout, adr_out to 0 and out_valid to 0; in_ready=1 during reset.
REQ-028 SHALL discard any in-flight WB op on reset mid-operation, with no register write.

Structure
REQ-029 SHALL place FS encodings (enum), flag bit indices and control-field offset functions of AW in shared package up_pkg.
REQ-030 SHALL isolate ALU+shifter+flag logic in combinational sub-module unidad_funcional, parametrised by W.
REQ-031 SHALL keep register file and pipeline registers in the top module.

Verification (W=4, NREG=8)
REQ-032 SHALL cover load: DA=3 MD=1 RW=1 datain=4'hA, then AA=3 FS=0000 -> adr_out=4'hA, flags Z=0 N=1.
REQ-033 SHALL cover forwarding: load R1=5 then immediately AA=BA=1 FS=0010 DA=2 RW=1 -> F=4'hA, V=1 C=0 N=1 Z=0, R2=4'hA.
REQ-034 SHALL cover subtract equal: R1=5, FS=0101 AA=BA=1 -> F=0, Z=1 C=1 V=0.
REQ-035 SHALL cover backpressure: out_ready=0 for 3 cycles -> outputs frozen, in_ready=0, single write to DA on release.
REQ-036 SHALL cover shift: MB=1 constant_in=4'b1001 FS=1110 -> F=4'b0010, C=1, V=0.
REQ-037 SHALL cover reset mid-op: rst_n low while out_valid=1 -> out_valid=0 immediately, all registers read back 0.

Source files
------------

// File: rtl/up_pkg.sv
// ---------------------------------------------------------------------------
// up_pkg -- shared definitions for the two-stage processing unit.
//
// Contents:
//   fs_e        : 4-bit function-select encodings of the function unit
//   FLAG_*      : bit positions inside the 4-bit {V,C,N,Z} flag vector
//   control-word field offsets: fixed LSB positions for the low fields and
//   helper functions for the address fields, whose position depends on AW
//
// Control word layout, MSB -> LSB:
//   DA[AW] | AA[AW] | BA[AW] | MB | FS[4] | MD | RW
// ---------------------------------------------------------------------------
package up_pkg;

    typedef enum logic [3:0] {
        FS_TSF_A     = 4'b0000,  // F = A
        FS_INC_A     = 4'b0001,  // F = A + 1
        FS_ADD       = 4'b0010,  // F = A + B
        FS_ADD_INC   = 4'b0011,  // F = A + B + 1
        FS_ADD_NOTB  = 4'b0100,  // F = A + ~B
        FS_SUB       = 4'b0101,  // F = A + ~B + 1 (A - B)
        FS_DEC_A     = 4'b0110,  // F = A - 1
        FS_TSF_A_ALT = 4'b0111,  // F = A (second encoding)
        FS_AND       = 4'b1000,
        FS_OR        = 4'b1001,
        FS_XOR       = 4'b1010,
        FS_NOT_A     = 4'b1011,
        FS_TSF_B     = 4'b1100,  // F = B
        FS_SHR_B     = 4'b1101,  // F = B >> 1, zero fill
        FS_SHL_B     = 4'b1110,  // F = B << 1, zero fill
        FS_ZERO      = 4'b1111
    } fs_e;

    // Flag vector is {V,C,N,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Fixed-position low fields of the control word
    localparam int RW_BIT = 0;
    localparam int MD_BIT = 1;
    localparam int FS_LSB = 2;
    localparam int MB_BIT = 6;
    localparam int BA_LSB = 7;

    function automatic int aa_lsb(input int aw);
        return BA_LSB + aw;
    endfunction

    function automatic int da_lsb(input int aw);
        return BA_LSB + 2 * aw;
    endfunction

    function automatic int ctl_width(input int aw);
        return 3 * aw + 7;
    endfunction

endpackage

// File: rtl/unidad_funcional.sv
// ---------------------------------------------------------------------------
// unidad_funcional -- purely combinational ALU + shifter + flag generator.
//
// Ports:
//   a, b   [W-1:0] in  : operand buses A and B
//   fs     [3:0]   in  : function select (see up_pkg::fs_e)
//   f      [W-1:0] out : result
//   flags  [3:0]   out : {V,C,N,Z} of the result
//
// All arithmetic encodings (0000-0111) are folded into one adder computing
// A + Y + cin, so carry and overflow come from a single W-bit add.
// ---------------------------------------------------------------------------
module unidad_funcional
    import up_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   fs,
    output logic [W-1:0] f,
    output logic [3:0]   flags
);

    logic [W-1:0] add_y;
    logic         add_cin;
    logic         arith;
    logic [W:0]   sum;
    logic         carry;
    logic         ovf;

    // Select the second adder operand and carry-in for the arithmetic group
    always_comb begin
        add_y   = '0;
        add_cin = 1'b0;
        arith   = 1'b1;
        case (fs_e'(fs))
            FS_TSF_A, FS_TSF_A_ALT: begin
            end
            FS_INC_A: add_cin = 1'b1;
            FS_ADD: add_y = b;
            FS_ADD_INC: begin
                add_y   = b;
                add_cin = 1'b1;
            end
            FS_ADD_NOTB: add_y = ~b;
            FS_SUB: begin
                add_y   = ~b;
                add_cin = 1'b1;
            end
            // A - 1 is A + all-ones: carry out is set unless A == 0
            FS_DEC_A: add_y = '1;
            default: arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, a} + {1'b0, add_y} + {{W{1'b0}}, add_cin};

    always_comb begin
        f     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        if (arith) begin
            f     = sum[W-1:0];
            carry = sum[W];
            // Signed overflow: operands share a sign the result does not
            ovf   = (a[W-1] == add_y[W-1]) && (sum[W-1] != a[W-1]);
        end else begin
            case (fs_e'(fs))
                FS_AND:   f = a & b;
                FS_OR:    f = a | b;
                FS_XOR:   f = a ^ b;
                FS_NOT_A: f = ~a;
                FS_TSF_B: f = b;
                FS_SHR_B: begin
                    f     = {1'b0, b[W-1:1]};
                    carry = b[0];
                end
                FS_SHL_B: begin
                    f     = {b[W-2:0], 1'b0};
                    carry = b[W-1];
                end
                default:  f = '0;
            endcase
        end
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_V] = ovf;
        flags[FLAG_C] = carry;
        flags[FLAG_N] = f[W-1];
        flags[FLAG_Z] = (f == '0);
    end

endmodule

// File: rtl/unidad_procesadora_pipe.sv
// ---------------------------------------------------------------------------
// unidad_procesadora_pipe -- two-stage (EX -> WB) datapath with a register
// file, operand forwarding and valid/ready handshakes on both sides.
//
// Ports:
//   clk          in        : clock, all state on rising edge
//   rst_n        in        : asynchronous active-low reset
//   in_valid     in        : control word / operands presented
//   in_ready     out       : op accepted this cycle when in_valid is high
//   control      in  [CW]  : {DA, AA, BA, MB, FS[4], MD, RW}
//   datain       in  [W]   : external writeback data (MD = 1)
//   constant_in  in  [W]   : replaces bus B when MB = 1
//   flags        out [4]   : {V,C,N,Z} of the op held in WB
//   dataout      out [W]   : bus B value of the op held in WB
//   adr_out      out [W]   : bus A value of the op held in WB
//   out_valid    out       : WB holds a valid op
//   out_ready    in        : downstream takes the WB op this cycle
//
// EX reads the register file, muxes the operands and runs the function unit;
// the results are registered into WB. The register file is written when the
// WB op leaves (out_valid && out_ready), so a reader in EX on that same cycle
// gets the value through the forwarding path instead of the stale register.
// ---------------------------------------------------------------------------
module unidad_procesadora_pipe
    import up_pkg::*;
#(
    parameter int W    = 4,
    parameter int NREG = 8,
    localparam int AW  = $clog2(NREG),
    localparam int CW  = ctl_width(AW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] control,
    input  logic [W-1:0]  datain,
    input  logic [W-1:0]  constant_in,
    output logic [3:0]    flags,
    output logic [W-1:0]  dataout,
    output logic [W-1:0]  adr_out,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int AA_LSB = aa_lsb(AW);
    localparam int DA_LSB = da_lsb(AW);

    // ---------------- control word decode (EX) ----------------
    logic [AW-1:0] ex_da;
    logic [AW-1:0] ex_aa;
    logic [AW-1:0] ex_ba;
    logic          ex_mb;
    logic [3:0]    ex_fs;
    logic          ex_md;
    logic          ex_rw;

    assign ex_da = control[DA_LSB +: AW];
    assign ex_aa = control[AA_LSB +: AW];
    assign ex_ba = control[BA_LSB +: AW];
    assign ex_mb = control[MB_BIT];
    assign ex_fs = control[FS_LSB +: 4];
    assign ex_md = control[MD_BIT];
    assign ex_rw = control[RW_BIT];

    // ---------------- state ----------------
    logic [W-1:0]  regs [NREG];

    logic          out_valid_reg;
    logic [3:0]    flags_reg;
    logic [W-1:0]  dataout_reg;
    logic [W-1:0]  adr_out_reg;
    logic [AW-1:0] wb_da_reg;
    logic          wb_rw_reg;
    logic [W-1:0]  wb_wdata_reg;

    // ---------------- handshakes ----------------
    logic wb_fire;
    logic wb_write;
    logic accept;

    assign wb_fire  = out_valid_reg && out_ready;
    assign wb_write = wb_fire && wb_rw_reg;
    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    // ---------------- operand read with forwarding ----------------
    logic [W-1:0] reg_a;
    logic [W-1:0] reg_b;
    logic [W-1:0] bus_a;
    logic [W-1:0] bus_b;

    assign reg_a = regs[ex_aa];
    assign reg_b = regs[ex_ba];

    always_comb begin
        bus_a = reg_a;
        if (wb_write && (wb_da_reg == ex_aa)) begin
            bus_a = wb_wdata_reg;
        end
    end

    // The constant takes priority: forwarding into B only matters when
    // B actually comes from the register file.
    always_comb begin
        bus_b = reg_b;
        if (ex_mb) begin
            bus_b = constant_in;
        end else if (wb_write && (wb_da_reg == ex_ba)) begin
            bus_b = wb_wdata_reg;
        end
    end

    // ---------------- function unit ----------------
    logic [W-1:0] fu_f;
    logic [3:0]   fu_flags;
    logic [W-1:0] ex_wdata;

    unidad_funcional #(
        .W (W)
    ) u_funcional (
        .a     (bus_a),
        .b     (bus_b),
        .fs    (ex_fs),
        .f     (fu_f),
        .flags (fu_flags)
    );

    assign ex_wdata = ex_md ? datain : fu_f;

    // ---------------- register file ----------------
    // Written only on the WB transfer cycle; an op stalled by out_ready low,
    // or wiped by reset, never reaches the file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            regs[wb_da_reg] <= wb_wdata_reg;
        end
    end

    // ---------------- EX -> WB pipeline register ----------------
    // Loads on accept (which covers the same-cycle drain-and-refill case);
    // when WB drains with nothing behind it only out_valid drops, the
    // visible outputs keep their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            flags_reg     <= '0;
            dataout_reg   <= '0;
            adr_out_reg   <= '0;
            wb_da_reg     <= '0;
            wb_rw_reg     <= 1'b0;
            wb_wdata_reg  <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            flags_reg     <= fu_flags;
            dataout_reg   <= bus_b;
            adr_out_reg   <= bus_a;
            wb_da_reg     <= ex_da;
            wb_rw_reg     <= ex_rw;
            wb_wdata_reg  <= ex_wdata;
        end else if (wb_fire) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign flags     = flags_reg;
    assign dataout   = dataout_reg;
    assign adr_out   = adr_out_reg;

endmodule
